// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state and transaction owner.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction in flight: arbitrate in IDLE, present the registered
// request in REQ until mem_gnt_i, then route the response in RESP.
//
// Handshake: a requester holds req_i (and its fields) until it sees gnt_o,
// which is combinational and can only assert in IDLE; the memory side sees
// mem_req_o held with stable fields until a cycle where mem_gnt_i is high,
// and the response arrives as a single mem_rvalid_i pulse in a later cycle.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AWIDTH     = 32,
   parameter int DWIDTH     = 32,
   parameter int STARVE_MAX = 4
)
(
   input  logic                              clk,
   input  logic                              rst,
   // fetch requester
   input  logic                              if_req_i,
   input  logic [AWIDTH-1:0]                 if_addr_i,
   output logic                              if_gnt_o,
   output logic                              if_rvalid_o,
   output logic [DWIDTH-1:0]                 if_rdata_o,
   // data requester
   input  logic                              d_req_i,
   input  logic                              d_we_i,
   input  logic [AWIDTH-1:0]                 d_addr_i,
   input  logic [DWIDTH-1:0]                 d_wdata_i,
   input  logic [DWIDTH/8-1:0]               d_be_i,
   output logic                              d_gnt_o,
   output logic                              d_rvalid_o,
   output logic [DWIDTH-1:0]                 d_rdata_o,
   // memory port
   output logic                              mem_req_o,
   output logic                              mem_we_o,
   output logic [AWIDTH-1:0]                 mem_addr_o,
   output logic [DWIDTH-1:0]                 mem_wdata_o,
   output logic [DWIDTH/8-1:0]               mem_be_o,
   input  logic                              mem_gnt_i,
   input  logic                              mem_rvalid_i,
   input  logic [DWIDTH-1:0]                 mem_rdata_i,
   // status and debug visibility
   output logic                              busy_o,
   output state_t                            dbg_state,
   output logic [$clog2(STARVE_MAX+1)-1:0]   dbg_starve_cnt
);

   localparam int BW = DWIDTH / 8;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   state_t            state;
   state_t            state_next;
   logic [SW-1:0]     starve_cnt;
   owner_t            owner_q;
   logic              we_q;
   logic [AWIDTH-1:0] addr_q;
   logic [DWIDTH-1:0] wdata_q;
   logic [BW-1:0]     be_q;

   logic              pick_if;
   logic              pick_d;
   logic              take;
   logic              cap_we;
   logic [AWIDTH-1:0] cap_addr;
   logic [DWIDTH-1:0] cap_wdata;
   logic [BW-1:0]     cap_be;

   // Pick the winner: data first, unless fetch has lost STARVE_MAX times in a row.
   always_comb begin
      pick_if = 1'b0;
      pick_d  = 1'b0;
      if (state == IDLE) begin
         if (if_req_i && (!d_req_i || starve_cnt == STARVE_LIM)) begin
            pick_if = 1'b1;
         end else if (d_req_i) begin
            pick_d = 1'b1;
         end
      end
      take = pick_if | pick_d;
   end

   // Fields to capture for the winner; fetch is always a full-word read.
   always_comb begin
      cap_we    = 1'b0;
      cap_addr  = if_addr_i;
      cap_wdata = '0;
      cap_be    = '1;
      if (pick_d) begin
         cap_we    = d_we_i;
         cap_addr  = d_addr_i;
         cap_wdata = d_wdata_i;
         cap_be    = d_be_i;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (take)         state_next = REQ;
         REQ:     if (mem_gnt_i)    state_next = RESP;
         RESP:    if (mem_rvalid_i) state_next = IDLE;
         default:                   state_next = IDLE;
      endcase
   end

   // Register the winning request and its owner at grant time.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q <= OWN_IF;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if (take) begin
         owner_q <= pick_d ? OWN_D : OWN_IF;
         we_q    <= cap_we;
         addr_q  <= cap_addr;
         wdata_q <= cap_wdata;
         be_q    <= cap_be;
      end
   end

   // Count fetch losses to contested data grants; clear when fetch wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (pick_if) begin
         starve_cnt <= '0;
      end else if (pick_d && if_req_i && starve_cnt != STARVE_LIM) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // FSM outputs: grants, memory request, and response routing.
   always_comb begin
      if_gnt_o    = pick_if;
      d_gnt_o     = pick_d;
      mem_req_o   = (state == REQ);
      mem_we_o    = we_q;
      mem_addr_o  = addr_q;
      mem_wdata_o = wdata_q;
      mem_be_o    = be_q;
      if_rvalid_o = 1'b0;
      d_rvalid_o  = 1'b0;
      if_rdata_o  = '0;
      d_rdata_o   = '0;
      if (state == RESP && mem_rvalid_i) begin
         if (owner_q == OWN_D) begin
            d_rvalid_o = 1'b1;
            d_rdata_o  = we_q ? '0 : mem_rdata_i;
         end else begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
         end
      end
      busy_o         = (state != IDLE);
      dbg_state      = state;
      dbg_starve_cnt = starve_cnt;
   end

endmodule
